// File: rtl/mult_serial_framed.sv
// Serial-parallel multiplier: X is held in parallel, a arrives LSB first, and the
// product (a*X) mod 2^OUT_W leaves one registered bit per cycle, LSB first.
module mult_serial_framed #(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int OUT_W = M + N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [M-1:0] X,
  input  logic         a_bit,
  output logic         busy,
  output logic         p_bit,
  output logic         p_valid,
  output logic         p_last,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(M + N + 1);
  localparam logic [CW-1:0] LAST  = CW'(OUT_W - 1);
  localparam logic [CW-1:0] N_M1  = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [M-1:0]     x_q, x_d;
  logic             sm_q, sm_d;
  logic             a_msb_q, a_msb_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             p_bit_d, p_valid_d, p_last_d;

  // On acceptance the fresh operand and a cleared accumulator are used in the
  // same edge, so no partial sum or carry from a previous frame can leak in.
  logic             accept;
  logic [M-1:0]     x_use;
  logic             sm_use;
  logic [OUT_W-1:0] acc_use;
  logic             sbit;
  logic [M+N-1:0]   x_full;
  logic [OUT_W-1:0] x_ext;
  logic [OUT_W-1:0] sum;

  assign accept  = (state_q == IDLE) && start;
  assign x_use   = accept ? X : x_q;
  assign sm_use  = accept ? signed_mode : sm_q;
  assign acc_use = accept ? '0 : acc_q;
  // FLUSH feeds the sign-extended serial operand: 0 unsigned, bit N-1 signed.
  assign sbit    = (state_q == FLUSH) ? (sm_q & a_msb_q) : a_bit;
  assign x_full  = sm_use ? {{N{x_use[M-1]}}, x_use} : {{N{1'b0}}, x_use};
  assign x_ext   = x_full[OUT_W-1:0];
  // Accumulator holds the running sum above the current bit position; a W-bit
  // width is exact for every bit still to be emitted, so nothing is dropped.
  assign sum     = acc_use + (sbit ? x_ext : '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    sm_d      = sm_q;
    a_msb_d   = a_msb_q;
    acc_d     = acc_q;
    p_bit_d   = 1'b0;
    p_valid_d = 1'b0;
    p_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d       = X;
          sm_d      = signed_mode;
          a_msb_d   = 1'b0;
          acc_d     = sum >> 1;
          cnt_d     = CW'(1);
          p_valid_d = 1'b1;
          p_bit_d   = sum[0];
          p_last_d  = (OUT_W == 1);
          state_d   = (OUT_W == 1) ? IDLE : FEED;
        end
      end
      FEED, FLUSH: begin
        acc_d     = sum >> 1;
        cnt_d     = cnt_q + CW'(1);
        p_valid_d = 1'b1;
        p_bit_d   = sum[0];
        if (state_q == FEED && cnt_q == N_M1) a_msb_d = a_bit;
        if (cnt_q == LAST) begin
          p_last_d = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q >= N_M1) begin
          state_d = FLUSH;
        end else begin
          state_d = FEED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // p_valid marks a product bit; there is no backpressure, the consumer must
  // take every bit in the cycle it is valid. busy mirrors p_valid by design.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      sm_q    <= 1'b0;
      a_msb_q <= 1'b0;
      acc_q   <= '0;
      p_bit   <= 1'b0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      sm_q    <= sm_d;
      a_msb_q <= a_msb_d;
      acc_q   <= acc_d;
      p_bit   <= p_bit_d;
      p_valid <= p_valid_d;
      p_last  <= p_last_d;
      busy    <= p_valid_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_serial_framed.sv
// Bench for mult_serial_framed: one 16-bit-output and one 8-bit-output instance
// share the stimulus; a negedge monitor reassembles frames against expected queues.
module tb_mult_serial_framed;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic [7:0] X;
  logic       a_bit;
  logic [1:0] busy, pbit, pval, plast;
  logic [1:0] st16, st8;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q16[$];
  logic [15:0] exp_q8[$];

  logic [15:0] word[2];
  int          nbits[2];
  int          run_len[2];
  int          last_run[2];

  always #5 clk = ~clk;

  mult_serial_framed #(.M(8), .N(8), .OUT_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .X(X),
    .a_bit(a_bit), .busy(busy[0]), .p_bit(pbit[0]), .p_valid(pval[0]),
    .p_last(plast[0]), .dbg_state(st16)
  );

  mult_serial_framed #(.M(8), .N(8), .OUT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .X(X),
    .a_bit(a_bit), .busy(busy[1]), .p_bit(pbit[1]), .p_valid(pval[1]),
    .p_last(plast[1]), .dbg_state(st8)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: reassemble each frame and compare against the expected queue.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int          w;
      logic [15:0] exp_v;
      logic        have;
      w = (g == 0) ? 16 : 8;
      if (rst) begin
        nbits[g] = 0;
        word[g]  = '0;
        run_len[g] = 0;
      end else begin
        check($sformatf("busy_eq_valid dut%0d", g), {31'd0, busy[g]}, {31'd0, pval[g]});
        if (!pval[g]) check($sformatf("pbit_zero_idle dut%0d", g), {31'd0, pbit[g]}, 32'd0);
        if (pval[g]) begin
          run_len[g]++;
          if (nbits[g] < 16) word[g][nbits[g]] = pbit[g];
          nbits[g]++;
          check($sformatf("p_last_pos dut%0d bit%0d", g, nbits[g]), {31'd0, plast[g]},
                {31'd0, (nbits[g] == w)});
          if (plast[g] || nbits[g] >= w) begin
            have = 1'b0;
            exp_v = '0;
            if (g == 0 && exp_q16.size() > 0) begin have = 1'b1; exp_v = exp_q16.pop_front(); end
            if (g == 1 && exp_q8.size() > 0)  begin have = 1'b1; exp_v = exp_q8.pop_front(); end
            check($sformatf("frame_available dut%0d", g), {31'd0, have}, 32'd1);
            if (have) check($sformatf("product dut%0d", g), {16'd0, word[g]}, {16'd0, exp_v});
            nbits[g] = 0;
            word[g]  = '0;
          end
        end else if (run_len[g] != 0) begin
          last_run[g] = run_len[g];
          run_len[g]  = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive frame cycles 0..7 (start + serial a); returns at the start of cycle 8.
  task automatic send_frame(input logic sm, input logic [7:0] a, input logic [7:0] x,
                            input logic [15:0] e16, input logic [15:0] e8, input int ign_k);
    start = 1'b1;
    signed_mode = sm;
    X = x;
    a_bit = a[0];
    exp_q16.push_back(e16);
    exp_q8.push_back(e8);
    tick(1);
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      a_bit = a[k];
      if (k == ign_k) begin
        start = 1'b1;
        X = 8'h00;
        signed_mode = ~sm;
      end else begin
        start = 1'b0;
      end
      tick(1);
    end
    start = 1'b0;
    a_bit = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    for (int g = 0; g < 2; g++)
      check($sformatf("%s dut%0d", name, g), {28'd0, busy[g], pbit[g], pval[g], plast[g]}, 32'd0);
    check({name, " state16"}, {30'd0, st16}, 32'd0);
    check({name, " state8"}, {30'd0, st8}, 32'd0);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      nbits[g] = 0; word[g] = '0; run_len[g] = 0; last_run[g] = 0;
    end
    // Reset with start held high: reset must win.
    rst = 1'b1; start = 1'b1; signed_mode = 1'b0; X = 8'hFF; a_bit = 1'b1;
    tick(2);
    @(negedge clk);
    check_quiet("reset_state");
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; a_bit = 1'b0;
    tick(2);

    send_frame(1'b0, 8'hFF, 8'hFF, 16'hFE01, 16'h0001, -1); tick(10);
    send_frame(1'b1, 8'hFD, 8'h05, 16'hFFF1, 16'h00F1, -1); tick(10);
    send_frame(1'b1, 8'h80, 8'h80, 16'h4000, 16'h0000, -1); tick(10);
    send_frame(1'b1, 8'hFF, 8'h7F, 16'hFF81, 16'h0081, -1); tick(10);
    send_frame(1'b1, 8'h7F, 8'h80, 16'hC080, 16'h0080, -1); tick(10);

    // Back-to-back with an ignored start in cycle 5 of the first frame.
    send_frame(1'b0, 8'hFF, 8'hFF, 16'hFE01, 16'h0001, 5);
    tick(8);
    send_frame(1'b0, 8'h01, 8'h80, 16'h0080, 16'h0080, -1);
    tick(10);
    check("b2b_contiguous_valid", last_run[0], 32);

    // Reset in frame cycle 5 aborts the frame; nothing is expected from it.
    start = 1'b1; signed_mode = 1'b0; X = 8'hFF; a_bit = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_quiet($sformatf("abort_cycle%0d", 6 + c));
      @(posedge clk); #1;
    end
    tick(20);
    send_frame(1'b0, 8'h03, 8'h03, 16'h0009, 16'h0009, -1); tick(10);

    // Truncation cases for the 8-bit instance (full width shown for the other).
    send_frame(1'b0, 8'h10, 8'h10, 16'h0100, 16'h0000, -1); tick(10);
    send_frame(1'b0, 8'h0F, 8'h11, 16'h00FF, 16'h00FF, -1); tick(10);

    check("queue16_drained", exp_q16.size(), 0);
    check("queue8_drained", exp_q8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
